// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
interface imem_loader_if #(
    parameter int AW = 10
);
    logic          byte_valid_i;
    logic [7:0]    byte_data_i;
    logic          byte_ready_o;
    logic          we_o;
    logic [AW-1:0] waddr_o;
    logic [31:0]   wdata_o;

    // Loader side: consumes bytes, drives memory writes.
    modport master (
        input  byte_valid_i,
        input  byte_data_i,
        output byte_ready_o,
        output we_o,
        output waddr_o,
        output wdata_o
    );

    // Environment side: supplies bytes, observes memory writes.
    modport slave (
        output byte_valid_i,
        output byte_data_i,
        input  byte_ready_o,
        input  we_o,
        input  waddr_o,
        input  wdata_o
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a program as a little-endian byte
// stream, writes it word by word into instruction memory, keeps a running
// checksum and holds the core in reset until a complete program is in place.
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [AW:0]   len_i,
    imem_loader_if.master bus,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          cpu_rst_no,
    output logic [31:0]   checksum_o
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [AW:0]   word_cnt_q, word_cnt_d;
    logic [AW:0]   len_q, len_d;
    logic [23:0]   word_q, word_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   checksum_q, checksum_d;
    logic          err_q, err_d;
    logic          cpu_rst_q, cpu_rst_d;

    logic          len_legal;
    logic [AW:0]   word_cnt_inc;

    assign len_legal    = (len_i != '0) && (len_i <= DEPTH_L);
    assign word_cnt_inc = word_cnt_q + (AW+1)'(1);

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            word_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
            cpu_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            word_q     <= word_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
            cpu_rst_q  <= cpu_rst_d;
        end
    end

    // Next-state and datapath update; the 4th byte lands directly in the
    // registered write-data/address so they are valid throughout WRITE.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        word_d     = word_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        checksum_d = checksum_q;
        err_d      = err_q;
        cpu_rst_d  = cpu_rst_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_legal) begin
                        state_d    = RECV;
                        byte_cnt_d = '0;
                        word_cnt_d = '0;
                        checksum_d = '0;
                        err_d      = 1'b0;
                        len_d      = len_i;
                        cpu_rst_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                if (bus.byte_valid_i) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: word_d[7:0]   = bus.byte_data_i;
                        2'd1: word_d[15:8]  = bus.byte_data_i;
                        2'd2: word_d[23:16] = bus.byte_data_i;
                        default: begin
                            wdata_d = {bus.byte_data_i, word_q};
                            waddr_d = word_cnt_q[AW-1:0];
                            state_d = WRITE;
                        end
                    endcase
                end
            end
            WRITE: begin
                checksum_d = checksum_q + wdata_q;
                word_cnt_d = word_cnt_inc;
                state_d    = (word_cnt_inc == len_q) ? DONE : RECV;
            end
            DONE: begin
                cpu_rst_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.byte_ready_o = (state_q == RECV);
    assign bus.we_o         = (state_q == WRITE);
    assign bus.waddr_o      = waddr_q;
    assign bus.wdata_o      = wdata_q;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == DONE);
    assign err_o            = err_q;
    assign cpu_rst_no       = cpu_rst_q;
    assign checksum_o       = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len   = '0;
    logic          busy, done, err, cpu_rst_n;
    logic [31:0]   csum;

    imem_loader_if #(.AW(AW)) bus ();

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .len_i      (len),
        .bus        (bus),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .cpu_rst_no (cpu_rst_n),
        .checksum_o (csum)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    int            done_cnt  = 0;
    int            ready_cnt = 0;

    // Observe the write bus and status pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.we_o) begin
            wa_q.push_back(bus.waddr_o);
            wd_q.push_back(bus.wdata_o);
        end
        if (done) done_cnt++;
        if (bus.byte_ready_o) ready_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = (AW+1)'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        bus.byte_valid_i = 1'b0;
        repeat (gap) tick();
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = b;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.byte_ready_o;
            tick();
            n++;
        end
        bus.byte_valid_i = 1'b0;
        if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
        check("we_latency", 32'(bus.we_o), 32'd1);
    endtask

    // Called while the last WRITE cycle is current.
    task automatic finish_load();
        tick();
        check("done_latency", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        tick();
        check("done_pulse_end", 32'(done), 32'd0);
        check("cpu_rst_release", 32'(cpu_rst_n), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
    endtask

    task automatic check_two_word_program(input string tag);
        check({tag, "_nwrites"}, 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check({tag, "_addr0"}, 32'(wa_q[0]), 32'd0);
            check({tag, "_data0"}, wd_q[0], 32'h0000_0513);
            check({tag, "_addr1"}, 32'(wa_q[1]), 32'd1);
            check({tag, "_data1"}, wd_q[1], 32'h0010_0593);
        end
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_checksum"}, csum, 32'h0010_0AA6);
        check({tag, "_waddr_hold"}, 32'(bus.waddr_o), 32'd1);
        check({tag, "_wdata_hold"}, bus.wdata_o, 32'h0010_0593);
    endtask

    initial begin
        int rc;
        logic [31:0] model_sum;
        bit addr_ok, data_ok;

        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = '0;

        // Reset values
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.byte_ready_o), 32'd0);
        check("rst_we", 32'(bus.we_o), 32'd0);
        check("rst_waddr", 32'(bus.waddr_o), 32'd0);
        check("rst_wdata", bus.wdata_o, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_checksum", csum, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst_n), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic two-word load, back-to-back bytes
        clear_log();
        do_start(2);
        check("start_busy", 32'(busy), 32'd1);
        check("start_cpu_rst", 32'(cpu_rst_n), 32'd0);
        send_word(32'h0000_0513, 0);
        send_word(32'h0010_0593, 0);
        finish_load();
        check_two_word_program("basic");

        // Same load with a 3-cycle valid gap before every byte
        repeat (2) tick();
        clear_log();
        do_start(2);
        send_word(32'h0000_0513, 3);
        send_word(32'h0010_0593, 3);
        finish_load();
        check_two_word_program("gap");

        // Illegal lengths: 0 and DEPTH+1
        clear_log();
        rc = ready_cnt;
        do_start(0);
        check("len0_err", 32'(err), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_cpu_rst", 32'(cpu_rst_n), 32'd1);
        repeat (2) tick();
        do_start(DEPTH + 1);
        check("len1025_err", 32'(err), 32'd1);
        check("len1025_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("illegal_no_ready", 32'(ready_cnt - rc), 32'd0);
        check("illegal_no_writes", 32'(wa_q.size()), 32'd0);
        check("illegal_checksum_kept", csum, 32'h0010_0AA6);
        do_start(1);
        check("legal_clears_err", 32'(err), 32'd0);
        check("legal_cpu_rst_low", 32'(cpu_rst_n), 32'd0);
        check("legal_checksum_clr", csum, 32'd0);
        send_word(32'hDEAD_BEEF, 0);
        finish_load();
        check("len1_nwrites", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) check("len1_data", wd_q[0], 32'hDEAD_BEEF);
        check("len1_checksum", csum, 32'hDEAD_BEEF);

        // Reset after 6 bytes of a 2-word load
        repeat (2) tick();
        clear_log();
        do_start(2);
        send_word(32'h0000_0513, 0);
        send_byte(8'h93, 0);
        send_byte(8'h05, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(bus.byte_ready_o), 32'd0);
        check("midrst_waddr", 32'(bus.waddr_o), 32'd0);
        check("midrst_checksum", csum, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("midrst_nwrites", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) check("midrst_addr0", 32'(wa_q[0]), 32'd0);
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        check("midrst_cpu_rst", 32'(cpu_rst_n), 32'd0);

        // start_i pulsed during RECV and WRITE must not disturb the load
        clear_log();
        do_start(2);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        do_start(1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("ign_we", 32'(bus.we_o), 32'd1);
        do_start(1);
        send_word(32'h0010_0593, 0);
        finish_load();
        check_two_word_program("ignore");

        // Full-depth load of incrementing words
        repeat (2) tick();
        clear_log();
        do_start(DEPTH);
        model_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] w;
                w = 32'(i);
                send_byte(w[8*k +: 8], 0);
            end
            model_sum = model_sum + 32'(i);
        end
        finish_load();
        check("full_nwrites", 32'(wa_q.size()), 32'(DEPTH));
        addr_ok = 1'b1;
        data_ok = 1'b1;
        for (int i = 0; i < wa_q.size(); i++) begin
            if (32'(wa_q[i]) != 32'(i)) addr_ok = 1'b0;
            if (wd_q[i] != 32'(i)) data_ok = 1'b0;
        end
        check("full_addr_seq", 32'(addr_ok), 32'd1);
        check("full_data_seq", 32'(data_ok), 32'd1);
        check("full_last_waddr", 32'(bus.waddr_o), 32'(DEPTH - 1));
        check("full_checksum", csum, model_sum);
        check("full_done_cnt", 32'(done_cnt), 32'd1);
        repeat (3) tick();
        check("full_checksum_stable", csum, model_sum);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, default 1024, number of 32-bit instruction-memory words.
REQ-002 Parameter: AW, default 10, word-address width; DEPTH SHALL equal 2**AW.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  load request; honoured only in IDLE.
REQ-006 len_i  in  AW+1  words to load, sampled in the start cycle; legal range 1..DEPTH.
REQ-007 byte_valid_i  in  1  incoming program byte valid.
REQ-008 byte_data_i  in  8  incoming program byte.
REQ-009 byte_ready_o  out  1  loader accepts a byte this cycle.
REQ-010 we_o  out  1  instruction-memory write strobe, one cycle per word.
REQ-011 waddr_o  out  AW  word address of the write.
REQ-012 wdata_o  out  32  assembled instruction word.
REQ-013 busy_o  out  1  high in RECV, WRITE and DONE.
REQ-014 done_o  out  1  one-cycle pulse on load completion.
REQ-015 err_o  out  1  sticky illegal-length flag.
REQ-016 cpu_rst_no  out  1  active-low hold for the core's reset; low while the program is invalid or loading.
REQ-017 checksum_o  out  32  modulo-2^32 sum of all words written in the current or last load.

Function
REQ-018 FSM states SHALL be IDLE, RECV, WRITE and DONE.
REQ-019 IDLE: start_i=1 with 1<=len_i<=DEPTH -> RECV; clear byte count, word count, checksum and err_o; latch len_i; drive cpu_rst_no low from the next cycle.
REQ-020 IDLE: start_i=1 with len_i=0 or len_i>DEPTH -> set err_o=1, remain in IDLE, leave cpu_rst_no unchanged.
REQ-021 byte_ready_o SHALL be 1 only in RECV; a byte is accepted when byte_valid_i and byte_ready_o are both 1.
REQ-022 Accepted bytes SHALL be packed little-endian: byte k (k=0..3) goes to bits [8k+7:8k].
REQ-023 Acceptance of the 4th byte -> WRITE in the next cycle; a byte_valid_i gap of any length SHALL stall without loss.
REQ-024 WRITE (exactly one cycle): we_o=1, waddr_o=word count, wdata_o=assembled word, checksum_o += wdata_o, word count += 1.
REQ-025 WRITE -> DONE if the incremented word count equals the latched length, otherwise -> RECV.
REQ-026 DONE (one cycle): done_o=1, cpu_rst_no set to 1 from the next cycle, then -> IDLE.
REQ-027 Latency: 4th byte accepted in cycle N -> we_o in N+1; last write in cycle M -> done_o in M+1.
REQ-028 Peak throughput SHALL be 1 word per 5 cycles.
REQ-029 start_i outside IDLE SHALL be ignored.
REQ-030 waddr_o and wdata_o SHALL be registered and hold their last values when we_o=0.
REQ-031 Word address SHALL never exceed DEPTH-1; len_i=DEPTH writes addresses 0..DEPTH-1 with no wrap.
REQ-032 checksum_o SHALL remain stable after DONE until the next accepted start.

Reset
REQ-033 rst_ni low SHALL immediately force IDLE, byte_ready_o=0, we_o=0, waddr_o=0, wdata_o=0, busy_o=0, done_o=0, err_o=0, checksum_o=0 and cpu_rst_no=0.
REQ-034 Reset during a load SHALL discard the partial word and issue no further writes; cpu_rst_no stays 0 until a later load completes.

Verification
REQ-035 Reset, start_i with len_i=2, bytes 13 05 00 00 93 05 10 00 -> writes 0x00000513@0 and 0x00100593@1, done_o pulse, checksum_o=0x00100AA6, cpu_rst_no=1.
REQ-036 Same load with byte_valid_i deasserted 3 cycles between every byte -> identical writes, no lost or duplicated bytes.
REQ-037 start_i with len_i=0, then with len_i=1025 -> err_o=1, no byte_ready_o, no writes; a following legal start clears err_o.
REQ-038 rst_ni pulsed low after 6 bytes of a 2-word load -> exactly one write (addr 0), no done_o, cpu_rst_no=0.
REQ-039 len_i=1024 with an incrementing-word pattern -> 1024 writes at addresses 0..1023, no wrap, checksum matches the model.
REQ-040 start_i pulsed during RECV and WRITE -> ignored; latched length and word count unchanged.
